led_matrix_scan_controller: RTL and testbench
=============================================

LED_MATRIX_SCAN_CONTROLLER -- requirements
Module: led_matrix_scan_controller

Interface
REQ-001 Parameter DWELL_CYCLES, default 1000, is the number of clock cycles each column is driven (legal range >= 1).
REQ-002 Parameter BLANK_CYCLES, default 2, is the number of all-off cycles inserted before each column (legal range >= 1).
REQ-003 Port clk, input, 1 bit, is the single system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, is the asynchronous, active-high reset.
REQ-005 Port enable, input, 1 bit, starts scanning when 1 and stops scanning when 0.
REQ-006 Port image, input, 35 bits, carries the 5x7 frame; bits [7c+6:7c] are the rows of column c, c = 0..4.
REQ-007 Port image_valid, input, 1 bit, requests that image be loaded on this cycle.
REQ-008 Port image_ack, output, 1 bit, pulses for one cycle, one cycle after each accepted image_valid.
REQ-009 Port columns, output, 5 bits, is the active-low one-hot column select.
REQ-010 Port rows, output, 7 bits, is the active-high row drive for the selected column.
REQ-011 Port frame_done, output, 1 bit, pulses for one cycle at the end of column 4's drive period.

Function
REQ-012 All outputs SHALL be registered; a column SHALL be driven only while the FSM is in DRIVE.
REQ-013 FSM states: IDLE, BLANK, DRIVE; a cycle counter SHALL restart at 0 on every state entry.
REQ-014 In IDLE with enable=1, the FSM SHALL go to BLANK with col=0.
REQ-015 BLANK: columns=5'b11111, rows=0 for exactly BLANK_CYCLES cycles, then go to DRIVE.
REQ-016 DRIVE: columns[col]=0, other columns=1, rows=active[7col+6:7col] for exactly DWELL_CYCLES cycles, then go to BLANK.
REQ-017 On leaving DRIVE with col<4, col SHALL increment; with col=4, col SHALL wrap to 0 and frame_done SHALL pulse.
REQ-018 Frame period SHALL be 5*(BLANK_CYCLES+DWELL_CYCLES) cycles; the first column-0 drive SHALL begin BLANK_CYCLES+1 cycles after enable rises.
REQ-019 enable=0 in any state SHALL force IDLE on the next edge: columns=5'b11111, rows=0, col=0, no frame_done; the images SHALL be retained.
REQ-020 An image_valid SHALL write image into a pending buffer and set pending_full; last write wins if pending_full is already set, and every write SHALL be acked.
REQ-021 At the frame boundary (the REQ-017 wrap) with pending_full=1, pending SHALL copy to active and pending_full SHALL clear; the displayed image SHALL never change mid-frame.
REQ-022 In IDLE, a pending image SHALL copy to active on the next edge, so the first frame after enable shows the newest image.
REQ-023 An image_valid in the same cycle as the boundary swap SHALL load image directly into active, clear pending_full, and still be acked.
REQ-024 rows SHALL be the pure slice of active with no inversion; bit r of the slice drives row r.

Reset
REQ-025 reset=1 SHALL immediately set: state=IDLE, col=0, counter=0, active=0, pending=0, pending_full=0, columns=5'b11111, rows=0, image_ack=0, frame_done=0.
REQ-026 Reset asserted mid-frame SHALL blank the outputs without waiting for a clock edge; scanning SHALL resume from column 0 only after reset=0 and enable=1.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2)
REQ-027 Reset, load image=35'h7_FFFF_FFFF in IDLE, then enable -> 2 blank cycles; columns=5'b11110 and rows=7'h7F for 4 cycles; then columns 1..4 in order; frame_done pulses every 30 cycles.
REQ-028 Load an image where only bit 14 is set (column 2, row 0) -> rows=7'h01 only while columns=5'b11011; rows=0 in all other columns.
REQ-029 Mid-frame (while column 1 is driven), load image B -> columns 1..4 still show the old image; B appears from column 0 of the next frame; image_ack is a single pulse.
REQ-030 Two image_valid cycles within one frame (C then D) -> the next frame shows D; two acks are seen.
REQ-031 image_valid in the same cycle as the column-4 wrap -> the new image is shown from the immediately following column 0.
REQ-032 Drop enable during DRIVE, then assert reset mid-DRIVE -> columns=5'b11111 and rows=0 at the next edge (enable) or immediately (reset); after re-enable, scanning restarts at column 0 after 2 blank cycles.

Source files
------------

// File: rtl/led_matrix_scan_controller.sv
// 5x7 LED matrix column scanner with double-buffered image (pending -> active swap at frame boundary).
// Latency: all outputs registered, image_ack one cycle after image_valid; no backpressure, every image write is accepted.
module led_matrix_scan_controller #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [34:0] image,
    input  logic        image_valid,
    output logic        image_ack,
    output logic [4:0]  columns,
    output logic [6:0]  rows,
    output logic        frame_done
);

    localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      col, col_nxt;
    logic            wrap;
    logic [34:0]     active, pending;
    logic            pending_full;
    logic [4:0][6:0] active_cols;

    assign active_cols = active;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        col_nxt   = col;
        wrap      = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            col_nxt   = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    col_nxt   = 3'd0;
                end
                BLANK: begin
                    if (cnt == CW'(BLANK_CYCLES - 1)) begin
                        state_nxt = DRIVE;
                        cnt_nxt   = '0;
                    end
                end
                DRIVE: begin
                    if (cnt == CW'(DWELL_CYCLES - 1)) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        if (col == 3'd4) begin
                            col_nxt = 3'd0;
                            wrap    = 1'b1;
                        end else begin
                            col_nxt = col + 3'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    col_nxt   = 3'd0;
                end
            endcase
        end
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            col        <= 3'd0;
            columns    <= 5'b11111;
            rows       <= 7'd0;
            frame_done <= 1'b0;
            image_ack  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            col        <= col_nxt;
            frame_done <= wrap;
            image_ack  <= image_valid;
            if (state_nxt == DRIVE) begin
                columns <= ~(5'b00001 << col_nxt);
                rows    <= active_cols[col_nxt];
            end else begin
                columns <= 5'b11111;
                rows    <= 7'd0;
            end
        end
    end

    // A write coinciding with the frame swap bypasses pending and lands straight in active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else if (wrap && image_valid) begin
            active       <= image;
            pending_full <= 1'b0;
        end else begin
            if ((wrap || state == IDLE) && pending_full) begin
                active       <= pending;
                pending_full <= 1'b0;
            end
            if (image_valid) begin
                pending      <= image;
                pending_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_controller.sv
// Directed + randomized bench for led_matrix_scan_controller (DWELL=4, BLANK=2) against a frame-position reference model.
module tb_led_matrix_scan_controller;

    localparam int DW = 4;
    localparam int BL = 2;
    localparam int SLOT = DW + BL;
    localparam int FRAME = 5 * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [34:0] image = '0;
    logic        image_valid = 1'b0;
    logic        image_ack;
    logic [4:0]  columns;
    logic [6:0]  rows;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    // Reference model: scan position p counts edges since scanning started.
    logic        m_run = 1'b0;
    int          m_p = 0;
    logic [34:0] m_act = '0;
    logic [34:0] m_pend = '0;
    logic        m_full = 1'b0;
    logic        m_ack = 1'b0;

    led_matrix_scan_controller #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .reset(reset), .enable(enable), .image(image),
        .image_valid(image_valid), .image_ack(image_ack), .columns(columns),
        .rows(rows), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_p = 0; m_act = '0; m_pend = '0; m_full = 1'b0; m_ack = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic iv, input logic [34:0] img);
        logic boundary, was_idle;
        boundary = en && m_run && ((m_p + 1) % FRAME == 0);
        was_idle = !m_run;
        if (boundary && iv) begin
            m_act = img; m_full = 1'b0;
        end else begin
            if ((boundary || was_idle) && m_full) begin
                m_act = m_pend; m_full = 1'b0;
            end
            if (iv) begin
                m_pend = img; m_full = 1'b1;
            end
        end
        if (!en) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1; m_p = 0;
        end else begin
            m_p++;
        end
        m_ack = iv;
    endtask

    task automatic compare_outputs();
        int c, w;
        logic [4:0] oh;
        logic [4:0] e_cols;
        logic [6:0] e_rows;
        logic       e_fd;
        e_cols = 5'b11111; e_rows = 7'd0; e_fd = 1'b0;
        if (m_run) begin
            c = (m_p % FRAME) / SLOT;
            w = (m_p % FRAME) % SLOT;
            if (w >= BL) begin
                oh = 5'b00001;
                oh = oh << c;
                e_cols = ~oh;
                e_rows = m_act[7*c +: 7];
            end
            e_fd = (m_p != 0) && (m_p % FRAME == 0);
        end
        chk("columns", 35'(columns), 35'(e_cols));
        chk("rows", 35'(rows), 35'(e_rows));
        chk("frame_done", 35'(frame_done), 35'(e_fd));
        chk("image_ack", 35'(image_ack), 35'(m_ack));
    endtask

    task automatic cyc(input logic en, input logic iv, input logic [34:0] img);
        enable = en; image_valid = iv; image = img;
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(en, iv, img);
        #1;
        compare_outputs();
    endtask

    function automatic logic [34:0] rnd_img();
        return 35'({$urandom(), $urandom()});
    endfunction

    initial begin
        int cnt, first, second;
        logic found;

        // Reset state, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_columns", 35'(columns), 35'h1F);
        chk("rst_rows", 35'(rows), 35'h0);
        chk("rst_ack", 35'(image_ack), 35'h0);
        chk("rst_fd", 35'(frame_done), 35'h0);
        cyc(1'b0, 1'b0, '0);
        reset = 1'b0;

        // All-on image loaded in IDLE, then enable; first drive BL+1 cycles after enable rises
        cyc(1'b0, 1'b1, 35'h7_FFFF_FFFF);
        cyc(1'b0, 1'b0, '0);
        found = 1'b0; cnt = 0;
        for (int i = 1; i <= 50 && !found; i++) begin
            cyc(1'b1, 1'b0, '0);
            if (columns == 5'b11110) begin found = 1'b1; cnt = i; end
        end
        chk("first_drive_delay", 35'(cnt), 35'(BL + 1));
        chk("first_drive_rows", 35'(rows), 35'h7F);

        // frame_done spacing
        first = -1; second = -1;
        for (int i = 0; i < 100 && second < 0; i++) begin
            cyc(1'b1, 1'b0, '0);
            if (frame_done) begin
                if (first < 0) first = i; else second = i;
            end
        end
        chk("frame_period", 35'(second - first), 35'(FRAME));

        // Single pixel: column 2, row 0
        cyc(1'b1, 1'b1, 35'h4000);
        for (int i = 0; i < 2 * FRAME; i++) cyc(1'b1, 1'b0, '0);

        // Mid-frame load while column 1 is driven
        for (int i = 0; i < FRAME && !(m_p % FRAME == SLOT + BL + 1); i++) cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, rnd_img());
        for (int i = 0; i < FRAME + 10; i++) cyc(1'b1, 1'b0, '0);

        // Two loads within one frame
        cyc(1'b1, 1'b1, rnd_img());
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, rnd_img());
        for (int i = 0; i < 2 * FRAME; i++) cyc(1'b1, 1'b0, '0);

        // Load on the column-4 wrap edge, with a stale pending image also present
        cyc(1'b1, 1'b1, rnd_img());
        for (int i = 0; i < FRAME && ((m_p + 1) % FRAME != 0); i++) cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, rnd_img());
        for (int i = 0; i < FRAME + 5; i++) cyc(1'b1, 1'b0, '0);

        // Drop enable during DRIVE, then re-enable
        for (int i = 0; i < FRAME && !(m_p % SLOT == BL + 1); i++) cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        chk("disable_blank_cols", 35'(columns), 35'h1F);
        cyc(1'b0, 1'b1, rnd_img());
        cyc(1'b0, 1'b0, '0);
        for (int i = 0; i < FRAME + 8; i++) cyc(1'b1, 1'b0, '0);

        // Asynchronous reset mid-DRIVE
        for (int i = 0; i < FRAME && !(m_p % SLOT == BL + 2); i++) cyc(1'b1, 1'b0, '0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_cols", 35'(columns), 35'h1F);
        chk("async_rst_rows", 35'(rows), 35'h0);
        cyc(1'b1, 1'b0, '0);
        reset = 1'b0;
        found = 1'b0; cnt = 0;
        for (int i = 1; i <= 50 && !found; i++) begin
            cyc(1'b1, 1'b0, '0);
            if (columns != 5'b11111) begin found = 1'b1; cnt = i; end
        end
        chk("restart_delay", 35'(cnt), 35'(BL + 1));
        chk("restart_col0", 35'(columns), 35'h1E);

        // Randomized tail
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) == 0), rnd_img());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
